// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end for a single shared combinational RV32I ALU.
// One transaction is in flight at a time. The request is latched in IDLE,
// presented to the ALU in EXEC, and the registered result is returned to its
// owner in RESP over a valid/ready handshake.
module alu_share_arbiter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [1:0]           req_valid_in,
    output logic [1:0]           req_ready_out,
    input  logic [2*XLEN-1:0]    req_op_1_in,
    input  logic [2*XLEN-1:0]    req_op_2_in,
    input  logic [7:0]           req_opcode_in,
    output logic [1:0]           rsp_valid_out,
    input  logic [1:0]           rsp_ready_in,
    output logic [XLEN-1:0]      rsp_result_out,
    output logic [XLEN-1:0]      alu_op_1_out,
    output logic [XLEN-1:0]      alu_op_2_out,
    output logic [3:0]           alu_opcode_out,
    input  logic [XLEN-1:0]      alu_result_in,
    output logic                 busy_out,
    output logic [2*CNT_W-1:0]   grant_cnt_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              last_grant_reg;
    logic              owner_reg;
    logic [XLEN-1:0]   op_1_reg;
    logic [XLEN-1:0]   op_2_reg;
    logic [3:0]        opcode_reg;
    logic [XLEN-1:0]   result_reg;
    logic [CNT_W-1:0]  grant_cnt_reg [2];

    logic              winner;
    logic [1:0]        grant;
    logic              accept;
    logic              rsp_done;

    // Pick the winner: the sole valid port, or on a tie the port that was not served last.
    always_comb begin
        winner = 1'b0;
        case (req_valid_in)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant_reg;
            default: winner = 1'b0;
        endcase
    end

    // Grant only in IDLE and never while reset is asserted; the response
    // completes only when the owning port is ready, the other port is ignored.
    assign grant    = (state_reg == IDLE && !rst_in && req_valid_in != 2'b00)
                      ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign accept   = |grant;
    assign rsp_done = (state_reg == RESP) && rsp_ready_in[owner_reg];

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs; rsp_valid is suppressed during reset so a dropped
    // transaction never shows a response.
    always_comb begin
        req_ready_out = grant;
        rsp_valid_out = 2'b00;
        if (state_reg == RESP && !rst_in) begin
            rsp_valid_out = owner_reg ? 2'b10 : 2'b01;
        end
        busy_out = (state_reg != IDLE);
    end

    // Request latch, result capture and round-robin history.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            op_1_reg       <= '0;
            op_2_reg       <= '0;
            opcode_reg     <= '0;
            owner_reg      <= 1'b0;
            result_reg     <= '0;
            last_grant_reg <= 1'b1;
        end else begin
            if (accept) begin
                op_1_reg   <= winner ? req_op_1_in[2*XLEN-1:XLEN] : req_op_1_in[XLEN-1:0];
                op_2_reg   <= winner ? req_op_2_in[2*XLEN-1:XLEN] : req_op_2_in[XLEN-1:0];
                opcode_reg <= winner ? req_opcode_in[7:4] : req_opcode_in[3:0];
                owner_reg  <= winner;
            end
            if (state_reg == EXEC) begin
                result_reg <= alu_result_in;
            end
            if (rsp_done) begin
                last_grant_reg <= owner_reg;
            end
        end
    end

    // Per-port accepted-request counters; they wrap freely.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    grant_cnt_reg[gi] <= '0;
                end else if (grant[gi]) begin
                    grant_cnt_reg[gi] <= grant_cnt_reg[gi] + CNT_W'(1);
                end
            end
            assign grant_cnt_out[gi*CNT_W +: CNT_W] = grant_cnt_reg[gi];
        end
    endgenerate

    // The ALU always sees the latched request, in every state.
    assign alu_op_1_out   = op_1_reg;
    assign alu_op_2_out   = op_2_reg;
    assign alu_opcode_out = opcode_reg;
    assign rsp_result_out = result_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: per-port request drivers, a small ALU model,
// and a response monitor that pops expected results from per-port queues.
module tb_alu_share_arbiter;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*XLEN-1:0]   req_op_1;
    logic [2*XLEN-1:0]   req_op_2;
    logic [7:0]          req_opcode;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [XLEN-1:0]     rsp_result;
    logic [XLEN-1:0]     alu_op_1;
    logic [XLEN-1:0]     alu_op_2;
    logic [3:0]          alu_opcode;
    logic [XLEN-1:0]     alu_result;
    logic                busy;
    logic [2*CNT_W-1:0]  grant_cnt;

    always #5 clk = ~clk;

    alu_share_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_op_1_in    (req_op_1),
        .req_op_2_in    (req_op_2),
        .req_opcode_in  (req_opcode),
        .rsp_valid_out  (rsp_valid),
        .rsp_ready_in   (rsp_ready),
        .rsp_result_out (rsp_result),
        .alu_op_1_out   (alu_op_1),
        .alu_op_2_out   (alu_op_2),
        .alu_opcode_out (alu_opcode),
        .alu_result_in  (alu_result),
        .busy_out       (busy),
        .grant_cnt_out  (grant_cnt)
    );

    // Combinational ALU stand-in.
    always_comb begin
        case (alu_opcode)
            4'b0000: alu_result = alu_op_1 + alu_op_2;
            4'b1000: alu_result = alu_op_1 - alu_op_2;
            4'b0111: alu_result = alu_op_1 & alu_op_2;
            4'b0110: alu_result = alu_op_1 | alu_op_2;
            4'b0100: alu_result = alu_op_1 ^ alu_op_2;
            default: alu_result = '0;
        endcase
    end

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      op;
    } req_t;

    req_t            req_q0[$];
    req_t            req_q1[$];
    logic [XLEN-1:0] exp_q0[$];
    logic [XLEN-1:0] exp_q1[$];
    int              acc_port_q[$];
    int              acc_cyc_q[$];
    int              rsp_port_q[$];
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic issue(input int port, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [3:0] op, input logic [XLEN-1:0] res, input bit want_rsp);
        req_t r;
        r.a = a; r.b = b; r.op = op;
        if (port == 0) begin
            req_q0.push_back(r);
            if (want_rsp) exp_q0.push_back(res);
        end else begin
            req_q1.push_back(r);
            if (want_rsp) exp_q1.push_back(res);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        acc_port_q.delete();
        acc_cyc_q.delete();
        rsp_port_q.delete();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((req_q0.size() + req_q1.size() + exp_q0.size() + exp_q1.size()) != 0 || busy) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                chk({name, "_timeout"}, 64'(n), 64'd0);
                return;
            end
        end
    endtask

    // Request drivers: present the head of each port queue, retire it after acceptance.
    initial begin
        logic [1:0] acc;
        req_valid  = 2'b00;
        req_op_1   = '0;
        req_op_2   = '0;
        req_opcode = '0;
        forever begin
            @(negedge clk);
            acc = req_ready & req_valid;
            if (acc[0]) begin acc_port_q.push_back(0); acc_cyc_q.push_back(cyc); end
            if (acc[1]) begin acc_port_q.push_back(1); acc_cyc_q.push_back(cyc); end
            @(posedge clk);
            #1;
            if (acc[0] && req_q0.size() > 0) req_q0.delete(0);
            if (acc[1] && req_q1.size() > 0) req_q1.delete(0);
            req_valid = 2'b00;
            if (req_q0.size() > 0) begin
                req_valid[0]        = 1'b1;
                req_op_1[XLEN-1:0]  = req_q0[0].a;
                req_op_2[XLEN-1:0]  = req_q0[0].b;
                req_opcode[3:0]     = req_q0[0].op;
            end
            if (req_q1.size() > 0) begin
                req_valid[1]           = 1'b1;
                req_op_1[2*XLEN-1:XLEN] = req_q1[0].a;
                req_op_2[2*XLEN-1:XLEN] = req_q1[0].b;
                req_opcode[7:4]        = req_q1[0].op;
            end
        end
    end

    // Response monitor: every completed handshake is checked against the owner's queue.
    logic [XLEN-1:0] mon_exp;
    always @(negedge clk) begin
        if (!rst && (rsp_valid & rsp_ready) != 2'b00) begin
            rsp_port_q.push_back(rsp_valid[1] ? 1 : 0);
            if (rsp_valid == 2'b11) begin
                chk("rsp_valid_onehot", 64'(rsp_valid), 64'd0);
            end else if (rsp_valid[0]) begin
                if (exp_q0.size() == 0) chk("unexpected_rsp_p0", 64'(rsp_result), 64'hdead);
                else begin mon_exp = exp_q0.pop_front(); chk("rsp_p0", 64'(rsp_result), 64'(mon_exp)); end
            end else begin
                if (exp_q1.size() == 0) chk("unexpected_rsp_p1", 64'(rsp_result), 64'hdead);
                else begin mon_exp = exp_q1.pop_front(); chk("rsp_p1", 64'(rsp_result), 64'(mon_exp)); end
            end
        end
    end

    initial begin
        int n;
        int rsp_before;
        rst       = 1'b1;
        rsp_ready = 2'b11;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        do_reset();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_alu_op_1", 64'(alu_op_1), 64'd0);
        chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);

        // 1: port 0 ADD 1+1 with exact latency
        issue(0, 32'd1, 32'd1, 4'b0000, 32'd2, 1'b1);
        n = 0;
        while (req_ready != 2'b01 && n < 20) begin @(negedge clk); n++; end
        chk("t1_req_ready", 64'(req_ready), 64'h1);
        @(negedge clk);
        chk("t1_alu_op_1", 64'(alu_op_1), 64'd1);
        chk("t1_alu_op_2", 64'(alu_op_2), 64'd1);
        chk("t1_alu_opcode", 64'(alu_opcode), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_no_rsp_yet", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_result", 64'(rsp_result), 64'd2);
        drain("t1");

        // 2: tie after reset, port 0 first
        do_reset();
        issue(0, 32'd2, 32'd1, 4'b1000, 32'd1, 1'b1);
        issue(1, 32'd3, 32'd4, 4'b0000, 32'd7, 1'b1);
        drain("t2");
        chk("t2_acc_count", 64'(acc_port_q.size()), 64'd2);
        if (acc_port_q.size() == 2) begin
            chk("t2_first_port", 64'(acc_port_q[0]), 64'd0);
            chk("t2_second_port", 64'(acc_port_q[1]), 64'd1);
        end
        chk("t2_grant_cnt", 64'(grant_cnt), 64'h5);

        // 3: continuous contention, 6 ops alternate, accepts 3 cycles apart
        do_reset();
        issue(0, 32'd10, 32'd5,  4'b0000, 32'd15, 1'b1);
        issue(1, 32'd100, 32'd1, 4'b1000, 32'd99, 1'b1);
        issue(0, 32'hF0, 32'h3C, 4'b0111, 32'h30, 1'b1);
        issue(1, 32'hF0, 32'h0F, 4'b0110, 32'hFF, 1'b1);
        issue(0, 32'hFF, 32'h0F, 4'b0100, 32'hF0, 1'b1);
        issue(1, 32'd0, 32'd1,   4'b1000, 32'hFFFF_FFFF, 1'b1);
        drain("t3");
        chk("t3_acc_count", 64'(acc_port_q.size()), 64'd6);
        if (acc_port_q.size() == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("t3_order_%0d", i), 64'(acc_port_q[i]), 64'(i % 2));
            for (int i = 1; i < 6; i++) chk($sformatf("t3_gap_%0d", i), 64'(acc_cyc_q[i] - acc_cyc_q[i-1]), 64'd3);
        end
        chk("t3_grant_cnt", 64'(grant_cnt), 64'hF);

        // 4: response back-pressure, then non-owner ready
        do_reset();
        rsp_ready = 2'b00;
        issue(0, 32'd5, 32'd6, 4'b0000, 32'd11, 1'b1);
        issue(1, 32'd7, 32'd3, 4'b1000, 32'd4, 1'b1);
        n = 0;
        while (rsp_valid != 2'b01 && n < 20) begin @(negedge clk); n++; end
        chk("t4_reach_resp", 64'(rsp_valid), 64'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t4_hold_valid_%0d", i), 64'(rsp_valid), 64'h1);
            chk($sformatf("t4_hold_result_%0d", i), 64'(rsp_result), 64'd11);
            chk($sformatf("t4_hold_ready_%0d", i), 64'(req_ready), 64'd0);
            chk($sformatf("t4_hold_busy_%0d", i), 64'(busy), 64'd1);
        end
        rsp_ready = 2'b10;
        repeat (2) begin
            @(negedge clk);
            chk("t4_nonowner_ignored", 64'(rsp_valid), 64'h1);
        end
        rsp_ready = 2'b11;
        drain("t4");

        // 5: reset during EXEC drops the transaction
        do_reset();
        issue(0, 32'd9, 32'd9, 4'b1000, 32'd0, 1'b0);
        n = 0;
        while (req_ready != 2'b01 && n < 20) begin @(negedge clk); n++; end
        chk("t5_accept", 64'(req_ready), 64'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_before = rsp_port_q.size();
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_alu_op_1", 64'(alu_op_1), 64'd0);
        chk("t5_alu_op_2", 64'(alu_op_2), 64'd0);
        chk("t5_alu_opcode", 64'(alu_opcode), 64'd0);
        chk("t5_grant_cnt", 64'(grant_cnt), 64'd0);
        repeat (6) @(negedge clk);
        chk("t5_no_rsp", 64'(rsp_port_q.size() - rsp_before), 64'd0);

        // 6: counter wrap with a 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) issue(1, 32'(i), 32'(i), 4'b0000, 32'(2 * i), 1'b1);
        drain("t6");
        chk("t6_grant_cnt", 64'(grant_cnt), 64'h4);

        chk("final_q_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
